// File: rtl/reg_read_arbiter.sv
// Round-robin read arbiter in front of a shared 4:1 register mux.
// Each grant runs SEL (mux settle), CAP (capture) and ACK (one-cycle pulse) before re-arbitrating.
module reg_read_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [7:0]    req_addr,
    input  logic [DW-1:0] bus_data,
    output logic [1:0]    reg_sel,
    output logic [3:0]    gnt,
    output logic [3:0]    ack,
    output logic [DW-1:0] rd_data,
    output logic          busy
);
    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {IDLE, SEL, CAP, ACK} state_t;

    state_t                     state;
    logic [1:0]                 last_gnt;
    logic [NUM_REQ-1:0][1:0]    sel_xlat;
    logic [NUM_REQ-1:0]         cand;
    logic [1:0]                 win_idx;
    logic [1:0]                 idx;
    logic                       win_valid;

    // Mux encoding is the register id rotated down by one (A sits at 11).
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_xlat
        assign sel_xlat[g] = req_addr[2*g+1 -: 2] - 2'd1;
    end

    // Scan farthest-first so the requester nearest after last_gnt wins.
    always_comb begin
        cand      = (state == ACK) ? (req & ~gnt) : req;
        win_valid = 1'b0;
        win_idx   = last_gnt;
        idx       = last_gnt;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_gnt + 2'(k);
            if (cand[idx]) begin
                win_idx   = idx;
                win_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            reg_sel  <= 2'b00;
            rd_data  <= '0;
            last_gnt <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt      <= 4'b0001 << win_idx;
                        reg_sel  <= sel_xlat[win_idx];
                        last_gnt <= win_idx;
                        busy     <= 1'b1;
                        state    <= SEL;
                    end
                end
                SEL: state <= CAP;
                CAP: begin
                    rd_data <= bus_data;
                    ack     <= gnt;
                    state   <= ACK;
                end
                ACK: begin
                    ack <= '0;
                    if (win_valid) begin
                        gnt      <= 4'b0001 << win_idx;
                        reg_sel  <= sel_xlat[win_idx];
                        last_gnt <= win_idx;
                        state    <= SEL;
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter; the register mux is modelled from reg_sel.
module tb_reg_read_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] req_addr;
    logic [7:0] bus_data;
    logic [1:0] reg_sel;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [7:0] rd_data;
    logic       busy;

    int errs;
    int checks;

    reg_read_arbiter #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .bus_data(bus_data), .reg_sel(reg_sel), .gnt(gnt), .ack(ack),
        .rd_data(rd_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file contents: A=5A, B=B1, C=C2, D=D3; mux order is B,C,D,A.
    always_comb begin
        case (reg_sel)
            2'b00:   bus_data = 8'hB1;
            2'b01:   bus_data = 8'hC2;
            2'b10:   bus_data = 8'hD3;
            default: bus_data = 8'h5A;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated read from requester r; req dropped right after grant.
    task automatic read1(input int r, input logic [1:0] addr, input logic [1:0] exp_sel,
                         input logic [7:0] exp_data);
        req_addr[2*r +: 2] = addr;
        req = 4'b0001 << r;
        tick();
        chk("rd_gnt", gnt, 32'(4'b0001 << r));
        chk("rd_sel", reg_sel, exp_sel);
        chk("rd_busy", busy, 1);
        req = 4'b0000;
        tick();
        chk("rd_noack_sel", ack, 0);
        tick();
        chk("rd_ack", ack, 32'(4'b0001 << r));
        chk("rd_data", rd_data, exp_data);
        tick();
        chk("rd_ack_clr", ack, 0);
        chk("rd_gnt_clr", gnt, 0);
        chk("rd_idle", busy, 0);
    endtask

    logic [7:0] regval [4];

    initial begin
        errs = 0;
        checks = 0;
        req_addr = 8'h00;
        regval[0] = 8'h5A; regval[1] = 8'hB1; regval[2] = 8'hC2; regval[3] = 8'hD3;
        do_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", reg_sel, 0);
        chk("rst_data", rd_data, 0);

        // Single read of A from requester 0
        read1(0, 2'd0, 2'b11, 8'h5A);

        // Address map through requester 2
        read1(2, 2'd1, 2'b00, 8'hB1);
        read1(2, 2'd2, 2'b01, 8'hC2);
        read1(2, 2'd3, 2'b10, 8'hD3);
        read1(2, 2'd0, 2'b11, 8'h5A);
        chk("idle_hold_sel", reg_sel, 2'b11);

        // Fairness: all four requesting, requester i reads register i
        do_reset();
        req_addr = 8'b11_10_01_00;
        req = 4'b1111;
        tick();
        for (int t = 0; t < 8; t++) begin
            chk("rr_gnt", gnt, 32'(4'b0001 << (t % 4)));
            chk("rr_busy", busy, 1);
            tick();
            tick();
            chk("rr_ack", ack, 32'(4'b0001 << (t % 4)));
            chk("rr_data", rd_data, regval[t % 4]);
            if (t == 7) req = 4'b0000;
            tick();
        end
        chk("rr_end_idle", busy, 0);

        // Requester 1 drops req and changes address during SEL
        req_addr[3:2] = 2'd1;
        req = 4'b0010;
        tick();
        chk("mid_gnt", gnt, 4'b0010);
        chk("mid_sel", reg_sel, 2'b00);
        req = 4'b0000;
        req_addr[3:2] = 2'd3;
        tick();
        chk("mid_sel_hold", reg_sel, 2'b00);
        tick();
        chk("mid_ack", ack, 4'b0010);
        chk("mid_data", rd_data, 8'hB1);
        chk("mid_sel_hold2", reg_sel, 2'b00);
        tick();
        chk("mid_idle", busy, 0);

        // Reset asserted while in CAP aborts the transaction
        req_addr[1:0] = 2'd0;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_ack", ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sel", reg_sel, 0);
        chk("abort_data", rd_data, 0);
        tick();
        chk("abort_ack2", ack, 0);
        rst_n = 1'b1;
        req_addr[7:6] = 2'd3;
        req = 4'b1000;
        tick();
        chk("post_rst_gnt", gnt, 4'b1000);
        chk("post_rst_sel", reg_sel, 2'b10);
        req = 4'b0000;
        tick();
        tick();
        chk("post_rst_ack", ack, 4'b1000);
        chk("post_rst_data", rd_data, 8'hD3);
        tick();

        // Collision 0 and 2 after reset: 0 first, then 2 back-to-back
        do_reset();
        req_addr = 8'b00_10_00_00;
        req = 4'b0101;
        tick();
        chk("col_gnt0", gnt, 4'b0001);
        chk("col_sel0", reg_sel, 2'b11);
        tick();
        tick();
        chk("col_ack0", ack, 4'b0001);
        chk("col_data0", rd_data, 8'h5A);
        tick();
        chk("col_gnt2", gnt, 4'b0100);
        chk("col_sel2", reg_sel, 2'b01);
        chk("col_busy", busy, 1);
        chk("col_gap1", ack, 0);
        req = 4'b0000;
        tick();
        chk("col_gap2", ack, 0);
        tick();
        chk("col_ack2", ack, 4'b0100);
        chk("col_data2", rd_data, 8'hC2);
        tick();
        chk("col_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
